hvac_zone_scheduler: RTL and testbench

Shares the single heating/cooling plant between `NZONES` thermostat zones. Each zone's aircon controller raises a heat or cool request. The scheduler grants the plant to one zone at a time, round-robin, and opens that zone's damper valve. It enforces a minimum run time per grant and a dead time before any heat/cool reversal. It sits between the per-zone aircon controllers and the plant drivers.

---
 rtl/hvac_pkg.sv | 6 +
 rtl/hvac_rr_pick.sv | 24 ++
 rtl/hvac_zone_scheduler.sv | 115 +++++++++++
 tb/tb_hvac_zone_scheduler.sv | 129 ++++++++++++
 4 files changed

// File: rtl/hvac_pkg.sv
// Shared types for the HVAC zone scheduler: FSM states, plant mode, stats width.
package hvac_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef enum logic {HEAT, COOL} mode_t;
    localparam int GRANT_CNT_W = 16;
endpackage

// File: rtl/hvac_rr_pick.sv
// Combinational round-robin search: first set bit of req strictly after ptr, wrapping.
module hvac_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);
    always_comb begin
        found = 1'b0;
        idx   = '0;
        // k=N wraps back to ptr itself, so the current owner is checked last
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
    end
endmodule

// File: rtl/hvac_zone_scheduler.sv
// Round-robin plant scheduler for NZONES zones with minimum run time and reversal dead time.
// Define HVAC_SCHED_STATS_EN to add the saturating grant_count output.
module hvac_zone_scheduler
    import hvac_pkg::*;
#(
    parameter int NZONES   = 4,
    parameter int DWELL    = 16,
    parameter int DEADTIME = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NZONES-1:0] heat_req,
    input  logic [NZONES-1:0] cool_req,
    output logic              heating,
    output logic              cooling,
`ifdef HVAC_SCHED_STATS_EN
    output logic [GRANT_CNT_W-1:0] grant_count,
`endif
    output logic [NZONES-1:0] zone_valve
);
    localparam int CNT_MAX = (DWELL > DEADTIME) ? DWELL : DEADTIME;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PTR_W   = $clog2(NZONES);

    state_t             state, state_n;
    mode_t              mode, mode_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [NZONES-1:0]  eff_cool, mask;
    logic               found;
    logic [PTR_W-1:0]   idx;

    // heat wins when a zone asserts both requests
    assign eff_cool = cool_req & ~heat_req;

    always_comb begin
        mask = '0;
        case (state)
            IDLE:    mask = heat_req | cool_req;
            RUN:     mask = (mode == HEAT) ? heat_req : eff_cool;
            default: mask = '0;
        endcase
    end

    hvac_rr_pick #(.N(NZONES), .PW(PTR_W)) u_pick (
        .req   (mask),
        .ptr   (ptr),
        .found (found),
        .idx   (idx)
    );

    always_comb begin
        state_n = state;
        mode_n  = mode;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: if (found) begin
                ptr_n   = idx;
                mode_n  = heat_req[idx] ? HEAT : COOL;
                cnt_n   = CNT_W'(DWELL - 1);
                state_n = RUN;
            end
            RUN: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (found) begin
                    ptr_n = idx;
                    cnt_n = CNT_W'(DWELL - 1);
                end else begin
                    cnt_n   = CNT_W'(DEADTIME - 1);
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt != '0) cnt_n = cnt - 1'b1;
                else           state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // outputs are decoded from next state so they land in flops with no extra cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode       <= HEAT;
            ptr        <= PTR_W'(NZONES - 1);
            cnt        <= '0;
            heating    <= 1'b0;
            cooling    <= 1'b0;
            zone_valve <= '0;
        end else begin
            state      <= state_n;
            mode       <= mode_n;
            ptr        <= ptr_n;
            cnt        <= cnt_n;
            heating    <= (state_n == RUN) && (mode_n == HEAT);
            cooling    <= (state_n == RUN) && (mode_n == COOL);
            zone_valve <= (state_n == RUN) ? (NZONES'(1) << ptr_n) : '0;
        end
    end

`ifdef HVAC_SCHED_STATS_EN
    logic grant;
    assign grant = found && ((state == IDLE) || (state == RUN && cnt == '0));

    always_ff @(posedge clk) begin
        if (!rst_n)
            grant_count <= '0;
        else if (grant && grant_count != '1)
            grant_count <= grant_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Table-driven bench for hvac_zone_scheduler (NZONES=4, DWELL=16, DEADTIME=4);
// stats checks are compiled in when HVAC_SCHED_STATS_EN is defined.
module tb_hvac_zone_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] heat_req, cool_req;
    logic       heating, cooling;
    logic [3:0] zone_valve;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

`ifdef HVAC_SCHED_STATS_EN
    logic [15:0] grant_count;
    logic        rst2_n;
    logic [1:0]  heat2, cool2, valve2;
    logic        heating2, cooling2;
    logic [15:0] grant_count2;

    hvac_zone_scheduler #(.NZONES(2), .DWELL(1), .DEADTIME(1)) u_sat (
        .clk(clk), .rst_n(rst2_n), .heat_req(heat2), .cool_req(cool2),
        .heating(heating2), .cooling(cooling2), .grant_count(grant_count2),
        .zone_valve(valve2)
    );
`endif

    hvac_zone_scheduler #(.NZONES(4), .DWELL(16), .DEADTIME(4)) dut (
        .clk(clk), .rst_n(rst_n), .heat_req(heat_req), .cool_req(cool_req),
        .heating(heating), .cooling(cooling),
`ifdef HVAC_SCHED_STATS_EN
        .grant_count(grant_count),
`endif
        .zone_valve(zone_valve)
    );

    typedef struct {
        bit         rst;
        logic [3:0] h, c;
        int         n;
        logic       eh, ec;
        logic [3:0] ev;
        string      name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input logic [3:0] h, input logic [3:0] c, input int n,
                       input logic eh, input logic ec, input logic [3:0] ev, input string name);
        vec_t v;
        v.rst = rst; v.h = h; v.c = c; v.n = n; v.eh = eh; v.ec = ec; v.ev = ev; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; heat_req = '0; cool_req = '0;
`ifdef HVAC_SCHED_STATS_EN
        rst2_n = 1'b0; heat2 = '0; cool2 = '0;
`endif
        //   rst h       c       n   eh ec valve
        add(1, 4'b0000, 4'b0000, 1,  0, 0, 4'b0000, "reset");
        add(0, 4'b0100, 4'b0000, 2,  1, 0, 4'b0100, "single_grant");
        add(0, 4'b0000, 4'b0000, 14, 1, 0, 4'b0100, "single_dwell");
        add(0, 4'b0000, 4'b0000, 6,  0, 0, 4'b0000, "single_off");
        add(0, 4'b0001, 4'b0001, 1,  1, 0, 4'b0001, "conflict_grant");
        add(0, 4'b0000, 4'b0000, 15, 1, 0, 4'b0001, "conflict_dwell");
        add(0, 4'b0000, 4'b0000, 6,  0, 0, 4'b0000, "conflict_off");
        add(0, 4'b1000, 4'b0000, 3,  1, 0, 4'b1000, "prerst_run");
        add(1, 4'b1000, 4'b0000, 1,  0, 0, 4'b0000, "reset_mid_run");
        add(0, 4'b0000, 4'b0000, 2,  0, 0, 4'b0000, "post_reset_idle");
        add(0, 4'b0000, 4'b1011, 16, 0, 1, 4'b0001, "handover_z0");
        add(0, 4'b0000, 4'b1011, 16, 0, 1, 4'b0010, "handover_z1");
        add(0, 4'b0000, 4'b1011, 16, 0, 1, 4'b1000, "handover_z3");
        add(0, 4'b0000, 4'b1011, 16, 0, 1, 4'b0001, "handover_wrap");
        add(1, 4'b0000, 4'b0000, 1,  0, 0, 4'b0000, "reset2");
        add(0, 4'b0010, 4'b0000, 2,  1, 0, 4'b0010, "rev_heat");
        add(0, 4'b0000, 4'b0100, 14, 1, 0, 4'b0010, "rev_heat_hold");
        add(0, 4'b0000, 4'b0100, 5,  0, 0, 4'b0000, "rev_drain_idle");
        add(0, 4'b0000, 4'b0100, 2,  0, 1, 4'b0100, "rev_cool");
        add(1, 4'b0000, 4'b0000, 1,  0, 0, 4'b0000, "reset3");

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                rst_n = !tbl[i].rst; heat_req = tbl[i].h; cool_req = tbl[i].c;
                @(posedge clk); #1;
                n_chk++;
                if ({heating, cooling, zone_valve} !== {tbl[i].eh, tbl[i].ec, tbl[i].ev}) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got h=%b c=%b v=%b expected h=%b c=%b v=%b",
                             tbl[i].name, k, heating, cooling, zone_valve,
                             tbl[i].eh, tbl[i].ec, tbl[i].ev);
                end
            end
        end
        rst_n = 1'b1; heat_req = '0; cool_req = '0;

`ifdef HVAC_SCHED_STATS_EN
        check16("count_after_reset", grant_count, 16'd0);
        // grants at the first edge and at the two dwell expiries
        cool_req = 4'b1011;
        repeat (33) @(posedge clk);
        #1;
        check16("count_three_grants", grant_count, 16'd3);
        cool_req = '0;

        // DWELL=1 instance grants on every edge while a request is held
        @(posedge clk); #1;
        rst2_n = 1'b1; cool2 = 2'b01;
        repeat (65534) @(posedge clk);
        #1;
        check16("count_pre_sat", grant_count2, 16'hFFFE);
        repeat (70) @(posedge clk);
        #1;
        check16("count_saturated", grant_count2, 16'hFFFF);
        cool2 = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
